// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: registered N:1 word selector behind a valid/ready handshake.
//
// Each accepted transfer carries INPUTS candidate words and a select code. The
// selected word (or ERR_VALUE for an out-of-range code) is computed at the
// input and stored in a main register that drives the outputs. A one-entry
// skid register absorbs the transfer accepted while the output is stalled, so
// in_ready comes straight from a flop and has no path from out_ready.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-low reset
//   flush        synchronous pipeline clear (err_sticky is kept)
//   in_valid     upstream transfer valid
//   in_ready     block can accept a transfer (registered)
//   in_data      INPUTS candidate words, word k at [k*WIDTH +: WIDTH]
//   in_sel       select code
//   out_valid    out_data valid
//   out_ready    downstream accepts
//   out_data     selected word
//   out_sel_err  out_data came from an out-of-range select
//   err_sticky   an out-of-range select was accepted since reset
module mux_nto1_pipe #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       INPUTS    = 4,
  parameter int unsigned       SEL_WIDTH = 2,
  parameter logic [WIDTH-1:0]  ERR_VALUE = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]    in_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    err_sticky
);

  // Main (output) entry
  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_data;
  logic             r_m_err;
  // Skid (overflow) entry
  logic             r_s_valid;
  logic [WIDTH-1:0] r_s_data;
  logic             r_s_err;
  logic             r_err_sticky;

  logic             w_m_valid_next;
  logic [WIDTH-1:0] w_m_data_next;
  logic             w_m_err_next;
  logic             w_s_valid_next;
  logic [WIDTH-1:0] w_s_data_next;
  logic             w_s_err_next;
  logic             w_err_sticky_next;

  logic [WIDTH-1:0] w_word;
  logic             w_sel_err;
  logic             w_in_fire;
  logic             w_out_fire;

  // Input-side selection. Codes at or above INPUTS match no candidate and fall
  // through to ERR_VALUE with the error bit set.
  always_comb begin
    w_word    = ERR_VALUE;
    w_sel_err = 1'b1;
    for (int unsigned k = 0; k < INPUTS; k++) begin
      if (in_sel == SEL_WIDTH'(k)) begin
        w_word    = in_data[k*WIDTH +: WIDTH];
        w_sel_err = 1'b0;
      end
    end
  end

  // in_ready is simply the inverted skid valid flop.
  assign w_in_fire  = in_valid & ~r_s_valid;
  assign w_out_fire = r_m_valid & out_ready;

  always_comb begin
    w_m_valid_next    = r_m_valid;
    w_m_data_next     = r_m_data;
    w_m_err_next      = r_m_err;
    w_s_valid_next    = r_s_valid;
    w_s_data_next     = r_s_data;
    w_s_err_next      = r_s_err;
    w_err_sticky_next = r_err_sticky;

    if (flush) begin
      // Held and incoming transfers are discarded; the error history stays.
      w_m_valid_next = 1'b0;
      w_s_valid_next = 1'b0;
    end else begin
      if (w_in_fire && w_sel_err) begin
        w_err_sticky_next = 1'b1;
      end

      if (!r_m_valid || w_out_fire) begin
        // M is free this cycle. The skid entry is older than anything new, and
        // in_ready was low while it was held, so both cannot be present.
        if (r_s_valid) begin
          w_m_valid_next = 1'b1;
          w_m_data_next  = r_s_data;
          w_m_err_next   = r_s_err;
        end else if (w_in_fire) begin
          w_m_valid_next = 1'b1;
          w_m_data_next  = w_word;
          w_m_err_next   = w_sel_err;
        end else begin
          w_m_valid_next = 1'b0;
        end
        w_s_valid_next = 1'b0;
      end else if (w_in_fire) begin
        // M stalled: park the new transfer in the skid entry.
        w_s_valid_next = 1'b1;
        w_s_data_next  = w_word;
        w_s_err_next   = w_sel_err;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_err      <= 1'b0;
      r_s_valid    <= 1'b0;
      r_s_data     <= '0;
      r_s_err      <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_m_valid    <= w_m_valid_next;
      r_m_data     <= w_m_data_next;
      r_m_err      <= w_m_err_next;
      r_s_valid    <= w_s_valid_next;
      r_s_data     <= w_s_data_next;
      r_s_err      <= w_s_err_next;
      r_err_sticky <= w_err_sticky_next;
    end
  end

  assign in_ready    = ~r_s_valid;
  assign out_valid   = r_m_valid;
  assign out_data    = r_m_data;
  assign out_sel_err = r_m_err;
  assign err_sticky  = r_err_sticky;

endmodule
